// File: rtl/bcd_seq_ctrl.sv
// bcd_seq_ctrl
//   Converts a 13-bit unsigned value to four BCD digits using a sequential
//   shift-and-add-3 engine (13 shift cycles). It also multiplexes the last
//   completed result onto a 4-digit common-anode display with leading-zero
//   blanking.
//
//   State table
//     state | meaning
//     IDLE  | waiting for start; result registers hold the last conversion
//     SHIFT | one add-3 / shift-left step per cycle, 13 steps in total
//     DONE  | scratch copied into the result registers, done pulse issued
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   conversion request, sampled only in IDLE
//   binary     in   [12:0] value to convert, latched on an accepted start
//   busy       out  high in SHIFT or DONE
//   done       out  one-cycle pulse in the cycle the new result is visible
//   Thousands, Hundreds, Tens, Ones  out [3:0] registered BCD result
//   anode      out  [3:0] active-low digit enable, bit 0 = Ones
//   digit      out  [3:0] BCD value of the currently scanned digit
module bcd_seq_ctrl #(
  parameter int unsigned SCAN_DIV = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [12:0] binary,
  output logic        busy,
  output logic        done,
  output logic [3:0]  Thousands,
  output logic [3:0]  Hundreds,
  output logic [3:0]  Tens,
  output logic [3:0]  Ones,
  output logic [3:0]  anode,
  output logic [3:0]  digit
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  state_t      state_q, state_d;
  logic [12:0] sr_q, sr_d;
  logic [15:0] scr_q, scr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] res_q, res_d;
  logic        done_q, done_d;
  logic [15:0] scan_q;
  logic [1:0]  idx_q;
  logic [15:0] scr_adj;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    // Per-nibble correction; carries never cross nibble boundaries.
    scr_adj = {add3(scr_q[15:12]), add3(scr_q[11:8]),
               add3(scr_q[7:4]),   add3(scr_q[3:0])};
    state_d = state_q;
    sr_d    = sr_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = binary;
          scr_d   = '0;
          cnt_d   = 4'd13;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = {scr_adj[14:0], sr_q[12]};
        sr_d  = {sr_q[11:0], 1'b0};
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DONE;
      end
      DONE: begin
        // done is registered so it lines up with the updated result.
        res_d   = scr_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Display scan, free-running and independent of the converter
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q <= '0;
      idx_q  <= '0;
    end else if (scan_q == SCAN_LAST) begin
      scan_q <= '0;
      idx_q  <= idx_q + 2'd1;
    end else begin
      scan_q <= scan_q + 16'd1;
    end
  end

  // Outputs
  always_comb begin
    busy      = (state_q != IDLE);
    done      = done_q;
    Thousands = res_q[15:12];
    Hundreds  = res_q[11:8];
    Tens      = res_q[7:4];
    Ones      = res_q[3:0];
    digit     = res_q[4*idx_q +: 4];
    anode     = 4'b1111;
    case (idx_q)
      2'd0: anode = 4'b1110;
      2'd1: if (res_q[15:4] != 12'd0) anode = 4'b1101;
      2'd2: if (res_q[15:8] != 8'd0)  anode = 4'b1011;
      2'd3: if (res_q[15:12] != 4'd0) anode = 4'b0111;
      default: anode = 4'b1111;
    endcase
  end

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
module tb_bcd_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [12:0] binary;
  logic        busy, done;
  logic [3:0]  Thousands, Hundreds, Tens, Ones, anode, digit;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_seq_ctrl #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .binary(binary),
    .busy(busy), .done(done),
    .Thousands(Thousands), .Hundreds(Hundreds), .Tens(Tens), .Ones(Ones),
    .anode(anode), .digit(digit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One conversion started at the next edge N; observes 20 cycles after N.
  // poke_edge != 0 re-asserts start with poke_val at edge N+poke_edge.
  task automatic run_conv(input string tag, input logic [12:0] val,
                          input logic [3:0] e_t, input logic [3:0] e_h,
                          input logic [3:0] e_tn, input logic [3:0] e_o,
                          input int poke_edge, input logic [12:0] poke_val);
    int busy_n, done_n, done_k;
    binary = val;
    start  = 1'b1;
    step();
    start  = 1'b0;
    busy_n = 0; done_n = 0; done_k = -1;
    for (int k = 0; k < 20; k++) begin
      if (busy) busy_n++;
      if (done) begin done_n++; done_k = k; end
      if (poke_edge != 0 && k + 1 == poke_edge) begin
        start  = 1'b1;
        binary = poke_val;
      end else begin
        start  = 1'b0;
      end
      step();
    end
    chk({tag, "_busy_cycles"}, busy_n, 14);
    chk({tag, "_done_count"}, done_n, 1);
    chk({tag, "_done_cycle"}, done_k, 14);
    chk({tag, "_thousands"}, Thousands, e_t);
    chk({tag, "_hundreds"}, Hundreds, e_h);
    chk({tag, "_tens"}, Tens, e_tn);
    chk({tag, "_ones"}, Ones, e_o);
  endtask

  logic [3:0] exp_an  [4];
  logic [3:0] exp_dig [4];

  initial begin
    int n1110, n1111, nother, nbaddig, dn, mism, guard;
    rst = 1'b1; start = 1'b1; binary = 13'd8191;
    step();
    step();
    // start asserted alongside rst must be ignored
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", {Thousands, Hundreds, Tens, Ones}, 0);
    chk("rst_anode", anode, 4'b1110);
    chk("rst_digit", digit, 0);
    rst = 1'b0; start = 1'b0;
    step();
    chk("idle_busy", busy, 0);

    run_conv("c8191", 13'd8191, 4'd8, 4'd1, 4'd9, 4'd1, 0, 13'd0);

    run_conv("c0", 13'd0, 4'd0, 4'd0, 4'd0, 4'd0, 0, 13'd0);
    n1110 = 0; n1111 = 0; nother = 0; nbaddig = 0;
    for (int j = 0; j < 16; j++) begin
      if (anode == 4'b1110) n1110++;
      else if (anode == 4'b1111) n1111++;
      else nother++;
      if (digit != 4'd0) nbaddig++;
      step();
    end
    chk("zero_scan_ones_on", n1110, 4);
    chk("zero_scan_blank", n1111, 12);
    chk("zero_scan_other", nother, 0);
    chk("zero_scan_digit", nbaddig, 0);

    // Second start at edge N+3 while busy must be ignored.
    run_conv("c1000", 13'd1000, 4'd1, 4'd0, 4'd0, 4'd0, 3, 13'd42);

    // Reset in mid-conversion aborts it.
    dn = 0;
    binary = 13'd4095; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (done) dn++;
      step();
    end
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    if (done) dn++;
    chk("abort_busy", busy, 0);
    chk("abort_result", {Thousands, Hundreds, Tens, Ones}, 0);
    step();
    if (done) dn++;
    chk("abort_start_in_rst_ignored", busy, 0);
    chk("abort_no_done", dn, 0);
    run_conv("c59", 13'd59, 4'd0, 4'd0, 4'd5, 4'd9, 0, 13'd0);

    // Scan sequence for 0,3,0,7
    run_conv("c307", 13'd307, 4'd0, 4'd3, 4'd0, 4'd7, 0, 13'd0);
    exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b1111;
    exp_dig[0] = 4'd7;   exp_dig[1] = 4'd0;   exp_dig[2] = 4'd3;   exp_dig[3] = 4'd0;
    guard = 0;
    while (anode == 4'b1110 && guard < 10) begin step(); guard++; end
    while (anode != 4'b1110 && guard < 30) begin step(); guard++; end
    chk("scan_sync_found", (anode == 4'b1110), 1);
    mism = 0;
    for (int j = 0; j < 16; j++) begin
      if (anode != exp_an[j/4]) mism++;
      if (j < 12 && digit != exp_dig[j/4]) mism++;
      step();
    end
    chk("scan_307_sequence", mism, 0);

    // Back-to-back with start held high
    binary = 13'd123; start = 1'b1;
    step();
    mism = 0; dn = 0;
    for (int k = 0; k < 50; k++) begin
      if (done) dn++;
      if (done != ((k % 15) == 14)) mism++;
      step();
    end
    start = 1'b0;
    repeat (20) step();
    chk("b2b_done_pattern", mism, 0);
    chk("b2b_done_count", dn, 3);
    chk("b2b_result", {Thousands, Hundreds, Tens, Ones}, 16'h0123);
    chk("b2b_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_seq_ctrl.md
BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 16: clk cycles each display digit is held active; legal range 2..65535.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Port start  input  1  conversion request; sampled only in IDLE.
REQ-005 Port binary  input  13  unsigned value to convert (0..8191); sampled on accepted start.
REQ-006 Port busy  output  1  high while a conversion is in progress (SHIFT or DONE state).
REQ-007 Port done  output  1  single-cycle pulse; result registers updated.
REQ-008 Port Thousands, Hundreds, Tens, Ones  output  4 each  registered BCD result of last completed conversion.
REQ-009 Port anode  output  4  active-low one-hot digit enable for 4-digit display; bit 0 = Ones.
REQ-010 Port digit  output  4  BCD value of the digit currently enabled on anode.

Function
REQ-011 FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-012 IDLE with start=1: latch binary into a 13-bit shift register, clear 16-bit scratch BCD register, load bit counter with 13, go SHIFT.
REQ-013 IDLE with start=0: remain IDLE; no register other than scan logic changes.
REQ-014 Each SHIFT cycle: every scratch nibble >=5 gets +3 (4-bit, no carry across nibbles), then scratch shifts left one bit taking shift-register MSB in at bit 0; shift register shifts left; counter decrements.
REQ-015 SHIFT with counter reaching 0 after the update (13th shift): go DONE.
REQ-016 DONE (one cycle): copy scratch nibbles to Thousands/Hundreds/Tens/Ones, assert done, go IDLE next edge.
REQ-017 Latency: start sampled at edge N -> done high and results valid during the cycle following edge N+14; next start accepted at edge N+15.
REQ-018 start while busy=1 SHALL be ignored (not queued); binary changes while busy have no effect.
REQ-019 Result registers hold their value until the next DONE; they never show partial scratch values.
REQ-020 Scan: free-running counter 0..SCAN_DIV-1; on wrap, digit index advances 0->1->2->3->0 (Ones, Tens, Hundreds, Thousands).
REQ-021 anode SHALL be all-ones except the bit of the current index, which is 0; digit SHALL equal the result register of that index.
REQ-022 Leading-zero blanking: for index 3, 2 or 1, anode SHALL be 4'b1111 when that digit and all higher digits are 0; Ones is never blanked.
REQ-023 Scan logic runs independently of the FSM and is not stalled by conversions.
REQ-024 Inputs outside the 13-bit range do not exist; Thousands never exceeds 8.

Reset
REQ-025 rst=1 at an edge: FSM -> IDLE, counter and shift/scratch registers -> 0, busy=0, done=0, all result registers -> 0, scan counter and index -> 0, anode -> 4'b1110, digit -> 0.
REQ-026 rst during SHIFT or DONE SHALL abort the conversion with no done pulse and no result update; start sampled in the same cycle as rst is ignored.
REQ-027 First start is accepted at the first edge where rst=0 and FSM is IDLE.

Verification
REQ-028 binary=8191, start pulse at edge N -> done high only after edge N+14; Thousands=8, Hundreds=1, Tens=9, Ones=1; busy high for 14 cycles.
REQ-029 binary=0 -> all digits 0; scan shows only Ones enabled (anode 1110 at index 0, 1111 at indices 1..3).
REQ-030 binary=1000, then start at edge N+3 with binary=42 -> second start ignored; result 1,0,0,0; one done pulse.
REQ-031 binary=4095, rst asserted at edge N+7 -> no done, results 0; new start with 59 at N+9 -> 0,0,5,9 after 14 cycles.
REQ-032 Result 0,3,0,7 with SCAN_DIV=4 -> anode sequence 1110,1101,1011,1111 each held 4 cycles, digit 7,0,3 at first three slots.
REQ-033 Back-to-back: start held high continuously -> conversions complete every 15 cycles, each done exactly one cycle wide.
